// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine with IDLE/SHIFT/DONE sequencing.
// Shifts up to STEP bits per clock; done pulses for one cycle.
module shift_sequencer #(
  parameter  int WIDTH   = 32,
  parameter  int STEP    = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;

  logic [SHAMT_W-1:0] k;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   shifted;

  // Final step may be shorter than STEP so the counter never wraps.
  always_comb begin
    k   = (rem_q < STEP_K) ? rem_q : STEP_K;
    dbl = {work_q, work_q} >> k;
    unique case (op_q)
      OP_SLL:  shifted = work_q << k;
      OP_SRL:  shifted = work_q >> k;
      OP_SRA:  shifted = WIDTH'($signed(work_q) >>> k);
      default: shifted = dbl[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - k;
        if (rem_q == k) begin
          state_d  = S_DONE;
          result_d = shifted;
        end
      end
      default: begin
        if (start) begin
          op_d   = op_e'(op);
          work_d = src;
          rem_d  = shamt;
          if (shamt == '0) begin
            state_d  = S_DONE;
            result_d = src;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_SLL;
      work_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer, run on a STEP=1 and a STEP=4 instance.
// Each instance has its own stimulus so per-STEP timing can differ.
module tb_shift_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_r [2];
  logic        start_r [2];
  logic [1:0]  op_r    [2];
  logic [31:0] src_r   [2];
  logic [4:0]  shamt_r [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [31:0] res_w   [2];

  int nvec = 0;
  int nerr = 0;
  int steps [2] = '{1, 4};

  shift_sequencer #(.WIDTH(32), .STEP(1)) u0 (
    .clk(clk), .reset(reset_r[0]), .start(start_r[0]),
    .op(op_r[0]), .src(src_r[0]), .shamt(shamt_r[0]),
    .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0])
  );

  shift_sequencer #(.WIDTH(32), .STEP(4)) u1 (
    .clk(clk), .reset(reset_r[1]), .start(start_r[1]),
    .op(op_r[1]), .src(src_r[1]), .shamt(shamt_r[1]),
    .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1])
  );

  task automatic chk(input string tag, input int sel,
                     input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s step=%0d observed=%h expected=%h",
             tag, steps[sel], obs, exp);
    end
  endtask

  // Called one negedge after the accepting edge.
  task automatic wait_done(input int sel, output int nb, output int ncyc,
                           output bit seen);
    nb = 0; ncyc = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_w[sel]) begin
        seen = 1'b1;
        break;
      end
      if (busy_w[sel]) nb++;
      ncyc++;
      @(negedge clk);
    end
  endtask

  task automatic drive(input int sel, input logic [1:0] op,
                       input logic [31:0] src, input logic [4:0] sh);
    start_r[sel] = 1'b1;
    op_r[sel]    = op;
    src_r[sel]   = src;
    shamt_r[sel] = sh;
    @(negedge clk);
    start_r[sel] = 1'b0;
    src_r[sel]   = 32'hDEADBEEF;
    shamt_r[sel] = 5'd17;
  endtask

  task automatic do_op(input int sel, input string tag, input logic [1:0] op,
                       input logic [31:0] src, input logic [4:0] sh,
                       input logic [31:0] exp);
    int nb, nc, ebusy;
    bit seen;
    ebusy = (int'(sh) + steps[sel] - 1) / steps[sel];
    drive(sel, op, src, sh);
    wait_done(sel, nb, nc, seen);
    chk({tag, "_done"}, sel, 32'(seen), 32'd1);
    chk({tag, "_busy"}, sel, 32'(nb), 32'(ebusy));
    chk({tag, "_lat"}, sel, 32'(nc), 32'(ebusy));
    chk({tag, "_res"}, sel, res_w[sel], exp);
  endtask

  initial begin
    int nb, nc, pc, ebusy;
    bit seen, saw;
    for (int s = 0; s < 2; s++) begin
      reset_r[s] = 1'b1; start_r[s] = 1'b0;
      op_r[s] = 2'b00; src_r[s] = '0; shamt_r[s] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_busy", s, 32'(busy_w[s]), 32'd0);
      chk("rst_done", s, 32'(done_w[s]), 32'd0);
      chk("rst_res", s, res_w[s], 32'd0);
      reset_r[s] = 1'b0;
    end

    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      do_op(s, "srl2", 2'b01, 32'hFFFFFFFF, 5'd2, 32'h3FFFFFFF);
      @(negedge clk);
      chk("pulse_end", s, 32'(done_w[s]), 32'd0);
      do_op(s, "sra31", 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF);
      @(negedge clk);
      do_op(s, "sll0", 2'b00, 32'h12345678, 5'd0, 32'h12345678);
      @(negedge clk);

      // Rotate, then restart in the DONE cycle with no bubble.
      do_op(s, "ror1", 2'b11, 32'h00000001, 5'd1, 32'h80000000);
      do_op(s, "b2b_sll4", 2'b00, 32'h00000001, 5'd4, 32'h00000010);
      @(negedge clk);
      chk("b2b_idle", s, 32'(busy_w[s] | done_w[s]), 32'd0);

      // start pulse while busy must be ignored.
      pc = (s == 0) ? 3 : 2;
      drive(s, 2'b01, 32'hF0000000, 5'd8);
      nb = 0; nc = 0; seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        start_r[s] = 1'b0;
        if (done_w[s]) begin
          seen = 1'b1;
          break;
        end
        if (busy_w[s]) begin
          nb++;
          if (nb == pc) begin
            start_r[s] = 1'b1; src_r[s] = '0;
            op_r[s] = 2'b00; shamt_r[s] = 5'd0;
          end
        end
        @(negedge clk);
      end
      start_r[s] = 1'b0;
      ebusy = (8 + steps[s] - 1) / steps[s];
      chk("ign_done", s, 32'(seen), 32'd1);
      chk("ign_busy", s, 32'(nb), 32'(ebusy));
      chk("ign_res", s, res_w[s], 32'h00F00000);
      @(negedge clk);
      chk("ign_nodone", s, 32'(busy_w[s] | done_w[s]), 32'd0);

      // Reset in busy cycle 4 of a 20-bit shift.
      drive(s, 2'b00, 32'hA5A5A5A5, 5'd20);
      nb = 0;
      for (int i = 0; i < 10; i++) begin
        if (busy_w[s]) nb++;
        if (nb == 4) break;
        @(negedge clk);
      end
      chk("mid_busy4", s, 32'(nb), 32'd4);
      reset_r[s] = 1'b1;
      @(negedge clk);
      reset_r[s] = 1'b0;
      chk("mrst_busy", s, 32'(busy_w[s]), 32'd0);
      chk("mrst_done", s, 32'(done_w[s]), 32'd0);
      chk("mrst_res", s, res_w[s], 32'd0);
      saw = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done_w[s] || busy_w[s]) saw = 1'b1;
      end
      chk("mrst_quiet", s, 32'(saw), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
